bus_hub_n: RTL and testbench
============================

BUS_HUB_N -- requirements
Module: bus_hub_n

Interface
REQ-001 SHALL have parameter N_DEV, default 4, the number of device ports (1..16).
REQ-002 SHALL have parameter DEV_BASE, default all-zero, a packed N_DEV*32 vector; slice i is device i's base address.
REQ-003 SHALL have parameter DEV_MASK, default all-zero, a packed N_DEV*32 vector; slice i is device i's decode mask (1 = bit compared).
REQ-004 SHALL have parameter TIMEOUT, default 255, the ACCESS cycles allowed before an error response (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, returned on host_data_read for error reads.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 host_address  input  32  host request address.
REQ-009 host_data_write  input  32  host write data.
REQ-010 host_write_mask  input  4  byte enables for the write.
REQ-011 host_wen / host_ren  input  1 each  host write and read strobes.
REQ-012 host_data_read  output  32  registered read data.
REQ-013 host_ready  output  1  one-cycle completion pulse.
REQ-014 host_error  output  1  qualifies host_ready: unmapped or timed-out access.
REQ-015 device_address / device_data_write  output  N_DEV*32  latched address and write data, broadcast to every slice.
REQ-016 device_write_mask  output  N_DEV*4  latched mask, broadcast to every slice.
REQ-017 device_wen / device_ren  output  N_DEV  per-device strobes.
REQ-018 device_ready  input  N_DEV  per-device completion.
REQ-019 device_data_read  input  N_DEV*32  per-device read data.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-021 IDLE: host strobes SHALL be sampled only in this state.
REQ-022 On a sampled request, SHALL latch address, wdata, mask, op and the selected index.
REQ-023 Device i SHALL match when (host_address & DEV_MASK[i]) == (DEV_BASE[i] & DEV_MASK[i]); with several matches, the lowest index SHALL win.
REQ-024 With host_wen and host_ren both high, the access SHALL be a write and ren SHALL be ignored.
REQ-025 IDLE with a match SHALL go to ACCESS.
REQ-026 IDLE with no match SHALL go to RESP with host_error=1 and, for a read, host_data_read=ERR_DATA.
REQ-027 ACCESS: only the selected device's wen or ren SHALL be high, held as a level until device_ready of that device is seen; device_ready from other devices SHALL be ignored.
REQ-028 On the selected device_ready in ACCESS, the hub SHALL drop the strobe, register device_data_read (read only) and go to RESP.
REQ-029 RESP SHALL hold host_ready=1 for exactly one cycle, then go to IDLE.
REQ-030 Latency: request sampled at cycle 0 -> strobe at cycle 1 -> with device_ready at cycle 1, host_ready at cycle 2; unmapped access -> host_ready at cycle 1.
REQ-031 The host SHALL drop its strobes before the cycle after host_ready; a strobe still high in IDLE SHALL start a new transaction.
REQ-032 host_data_read SHALL hold its value until the next RESP.
REQ-033 host_data_read SHALL be unchanged after a write.

Reset
REQ-034 When rst is low at a clock edge, the FSM SHALL go to IDLE and every device_wen/ren, host_ready and host_error SHALL be 0.
REQ-035 At that reset, host_data_read, the latched address, wdata and mask SHALL be 0, and the timeout counter SHALL be cleared.
REQ-036 A reset during ACCESS SHALL abort the access with no host_ready pulse; strobes SHALL be low on the next cycle.

Configuration
REQ-037 With macro BUS_HUB_TIMEOUT_EN defined, a counter SHALL increment each ACCESS cycle.
REQ-038 With BUS_HUB_TIMEOUT_EN defined, once the counter reaches TIMEOUT without device_ready, the hub SHALL drop the strobe and go to RESP with host_error=1 and ERR_DATA for reads.
REQ-039 With BUS_HUB_TIMEOUT_EN defined, device_ready and expiry in the same cycle SHALL resolve as a normal completion.
REQ-040 Without BUS_HUB_TIMEOUT_EN, no counter SHALL exist, ACCESS SHALL wait indefinitely and host_error SHALL assert only for unmapped addresses.

Verification
REQ-041 N_DEV=2, DEV_BASE={0x00010000,0x00000000}, DEV_MASK={0xFFFF0000,0xFFFF0000}: read 0x00010004, dev1 ready at cycle 1 with 0x12345678 -> device_ren=2'b10 at cycle 1, host_ready and host_data_read=0x12345678 at cycle 2, host_error=0.
REQ-042 Write 0x00000008, data 0xCAFEF00D, mask 4'b0011 -> only device_wen[0] high; device_write_mask slice 0 = 0011; host_data_read unchanged.
REQ-043 Read 0x00020000 (unmapped) -> no device strobe; host_ready and host_error at cycle 1; host_data_read=0xDEADBEEF.
REQ-044 wen and ren high together to dev0 -> device_wen[0]=1, device_ren=0.
REQ-045 BUS_HUB_TIMEOUT_EN, TIMEOUT=4, dev0 never ready -> strobe high for exactly 4 cycles, then host_ready with host_error=1 and ERR_DATA; without the macro, the strobe is still high after 1000 cycles.
REQ-046 rst low for one cycle mid-ACCESS -> strobes 0 next cycle, no host_ready, next request served normally.

Source files
------------

// File: rtl/bus_hub_n.sv
// Single-master hub that decodes a host request onto one of N_DEV device ports.
// Define BUS_HUB_TIMEOUT_EN to bound each device access to TIMEOUT cycles.
module bus_hub_n #(
  parameter int                  N_DEV    = 4,
  parameter logic [N_DEV*32-1:0] DEV_BASE = '0,
  parameter logic [N_DEV*32-1:0] DEV_MASK = '0,
  parameter int                  TIMEOUT  = 255,
  parameter logic [31:0]         ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         host_address,
  input  logic [31:0]         host_data_write,
  input  logic [3:0]          host_write_mask,
  input  logic                host_wen,
  input  logic                host_ren,
  output logic [31:0]         host_data_read,
  output logic                host_ready,
  output logic                host_error,
  output logic [N_DEV*32-1:0] device_address,
  output logic [N_DEV*32-1:0] device_data_write,
  output logic [N_DEV*4-1:0]  device_write_mask,
  output logic [N_DEV-1:0]    device_wen,
  output logic [N_DEV-1:0]    device_ren,
  input  logic [N_DEV-1:0]    device_ready,
  input  logic [N_DEV*32-1:0] device_data_read
);

  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_n;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [3:0]         mask_q;
  logic               write_q, err_q;
  logic [IDX_W-1:0]   sel_q, hit_idx;
  logic               hit, host_req, sel_ready, expired;
  logic [N_DEV-1:0]   sel_vec;
  logic [31:0]        sel_rdata;

  assign host_req  = host_wen | host_ren;
  assign sel_ready = device_ready[sel_q];
  assign sel_rdata = device_data_read[sel_q*32 +: 32];

  // Walk from the top index down so the lowest matching device wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if ((host_address & DEV_MASK[i*32 +: 32]) == (DEV_BASE[i*32 +: 32] & DEV_MASK[i*32 +: 32])) begin
        hit     = 1'b1;
        hit_idx = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N_DEV; i++) begin
      sel_vec[i] = (sel_q == i[IDX_W-1:0]);
    end
  end

`ifdef BUS_HUB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt;

  // Counts ACCESS cycles; expiry fires on the TIMEOUT-th strobe cycle.
  always_ff @(posedge clk) begin
    if (!rst)                tmo_cnt <= '0;
    else if (state == ACCESS) tmo_cnt <= tmo_cnt + 16'd1;
    else                     tmo_cnt <= '0;
  end

  assign expired = (state == ACCESS) && (tmo_cnt == TMO_LAST);
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (host_req) state_n = hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || expired) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch and response data; device_ready takes priority over expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_req) begin
            addr_q  <= host_address;
            wdata_q <= host_data_write;
            mask_q  <= host_write_mask;
            write_q <= host_wen;
            sel_q   <= hit_idx;
            err_q   <= !hit;
            if (!hit && !host_wen) rdata_q <= ERR_DATA;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            err_q <= 1'b0;
            if (!write_q) rdata_q <= sel_rdata;
          end else if (expired) begin
            err_q <= 1'b1;
            if (!write_q) rdata_q <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign host_data_read    = rdata_q;
  assign host_ready        = (state == RESP);
  assign host_error        = (state == RESP) && err_q;
  assign device_address    = {N_DEV{addr_q}};
  assign device_data_write = {N_DEV{wdata_q}};
  assign device_write_mask = {N_DEV{mask_q}};
  assign device_wen        = (state == ACCESS &&  write_q) ? sel_vec : '0;
  assign device_ren        = (state == ACCESS && !write_q) ? sel_vec : '0;

endmodule

// File: tb/tb_bus_hub_n.sv
// Self-checking bench for bus_hub_n (two devices, 64 KiB windows at 0x0 and 0x10000).
// Honours BUS_HUB_TIMEOUT_EN when compiled alongside the RTL.
module tb_bus_hub_n;

  localparam int          N_DEV = 2;
  localparam logic [63:0] BASE  = {32'h00010000, 32'h00000000};
  localparam logic [63:0] MASK  = {32'hFFFF0000, 32'hFFFF0000};
  localparam int          TMO   = 4;
  localparam logic [31:0] ERRD  = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic [31:0] host_address, host_data_write, host_data_read;
  logic [3:0]  host_write_mask;
  logic        host_wen, host_ren, host_ready, host_error;
  logic [63:0] device_address, device_data_write, device_data_read;
  logic [7:0]  device_write_mask;
  logic [1:0]  device_wen, device_ren, device_ready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata;

  bus_hub_n #(
    .N_DEV(N_DEV), .DEV_BASE(BASE), .DEV_MASK(MASK), .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .host_address(host_address), .host_data_write(host_data_write),
    .host_write_mask(host_write_mask), .host_wen(host_wen), .host_ren(host_ren),
    .host_data_read(host_data_read), .host_ready(host_ready), .host_error(host_error),
    .device_address(device_address), .device_data_write(device_data_write),
    .device_write_mask(device_write_mask), .device_wen(device_wen), .device_ren(device_ren),
    .device_ready(device_ready), .device_data_read(device_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address map model: window index from the address range, -1 when unmapped.
  function automatic int ref_dev(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a < 32'h0002_0000) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one sampling edge, then releases the strobes.
  task automatic issue(input logic [31:0] a, input logic w, input logic r,
                       input logic [31:0] d, input logic [3:0] m);
    host_address    = a;
    host_data_write = d;
    host_write_mask = m;
    host_wen        = w;
    host_ren        = r;
    tick();
    host_wen = 1'b0;
    host_ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    host_wen = 1'b1; host_ren = 1'b1;
    host_address = 32'h4; host_data_write = 32'h55AA55AA; host_write_mask = 4'hF;
    device_ready = 2'b11; device_data_read = '1;
    tick(); tick();
    checks++; if (host_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", host_ready); end
    checks++; if (host_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", host_error); end
    checks++; if ({device_wen, device_ren} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes got %b want 0000", {device_wen, device_ren}); end
    checks++; if (host_data_read !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", host_data_read); end
    checks++; if ({device_address, device_data_write, device_write_mask} !== '0) begin errors++; $display("[TB] FAIL reset_latches got %h %h %h want 0", device_address, device_data_write, device_write_mask); end
    host_wen = 1'b0; host_ren = 1'b0; device_ready = 2'b00;
    rst = 1'b1;
    tick();
    exp_rdata = 32'h0;
  endtask

  task automatic test_read_dev1();
    issue(32'h00010004, 1'b0, 1'b1, 32'h0, 4'h0);
    checks++; if (device_ren !== 2'b10 || device_wen !== 2'b00) begin errors++; $display("[TB] FAIL read_strobe got ren=%b wen=%b want 10/00", device_ren, device_wen); end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_early_ready got %b want 0", host_ready); end
    device_ready = 2'b10;
    device_data_read = {32'h12345678, 32'h0BADF00D};
    tick();
    device_ready = 2'b00;
    exp_rdata = 32'h12345678;
    checks++; if (host_ready !== 1'b1 || host_error !== 1'b0) begin errors++; $display("[TB] FAIL read_resp got rdy=%b err=%b want 1/0", host_ready, host_error); end
    checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL read_data got %h want %h", host_data_read, exp_rdata); end
    tick();
    checks++; if (host_ready !== 1'b0 || device_ren !== 2'b00) begin errors++; $display("[TB] FAIL read_one_pulse got rdy=%b ren=%b want 0/00", host_ready, device_ren); end
  endtask

  task automatic test_write_dev0();
    device_data_read = {32'h11111111, 32'h22222222};
    issue(32'h00000008, 1'b1, 1'b0, 32'hCAFEF00D, 4'b0011);
    checks++; if (device_wen !== 2'b01 || device_ren !== 2'b00) begin errors++; $display("[TB] FAIL write_strobe got wen=%b ren=%b want 01/00", device_wen, device_ren); end
    checks++; if (device_write_mask !== 8'h33) begin errors++; $display("[TB] FAIL write_mask got %h want 33", device_write_mask); end
    checks++; if (device_data_write !== {2{32'hCAFEF00D}} || device_address !== {2{32'h8}}) begin errors++; $display("[TB] FAIL write_bcast got d=%h a=%h want cafef00d x2 / 8 x2", device_data_write, device_address); end
    device_ready = 2'b01;
    tick();
    device_ready = 2'b00;
    checks++; if (host_ready !== 1'b1 || host_error !== 1'b0) begin errors++; $display("[TB] FAIL write_resp got rdy=%b err=%b want 1/0", host_ready, host_error); end
    checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL write_rdata_kept got %h want %h", host_data_read, exp_rdata); end
    tick();
  endtask

  task automatic test_unmapped();
    issue(32'h00020000, 1'b0, 1'b1, 32'h0, 4'h0);
    exp_rdata = ERRD;
    checks++; if (host_ready !== 1'b1 || host_error !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_resp got rdy=%b err=%b want 1/1", host_ready, host_error); end
    checks++; if ({device_wen, device_ren} !== 4'b0) begin errors++; $display("[TB] FAIL unmapped_strobe got %b want 0000", {device_wen, device_ren}); end
    checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL unmapped_data got %h want %h", host_data_read, exp_rdata); end
    tick();
    checks++; if (host_ready !== 1'b0 || host_error !== 1'b0) begin errors++; $display("[TB] FAIL unmapped_pulse got rdy=%b err=%b want 0/0", host_ready, host_error); end
  endtask

  task automatic test_wen_ren_both();
    device_data_read = {32'h33333333, 32'h44444444};
    issue(32'h00000020, 1'b1, 1'b1, 32'h01020304, 4'hF);
    checks++; if (device_wen !== 2'b01 || device_ren !== 2'b00) begin errors++; $display("[TB] FAIL both_strobe got wen=%b ren=%b want 01/00", device_wen, device_ren); end
    device_ready = 2'b01;
    tick();
    device_ready = 2'b00;
    checks++; if (host_ready !== 1'b1 || host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL both_resp got rdy=%b data=%h want 1/%h", host_ready, host_data_read, exp_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic seen_ready;
    n = 0;
    seen_ready = 1'b0;
    device_ready = 2'b00;
    issue(32'h00000100, 1'b0, 1'b1, 32'h0, 4'h0);
`ifdef BUS_HUB_TIMEOUT_EN
    while (device_ren[0] === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    exp_rdata = ERRD;
    checks++; if (n != TMO) begin errors++; $display("[TB] FAIL timeout_len got %0d want %0d", n, TMO); end
    checks++; if (host_ready !== 1'b1 || host_error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_resp got rdy=%b err=%b want 1/1", host_ready, host_error); end
    checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL timeout_data got %h want %h", host_data_read, exp_rdata); end
    tick();
`else
    for (int k = 0; k < 1000; k++) begin
      if (host_ready === 1'b1) seen_ready = 1'b1;
      tick();
    end
    checks++; if (device_ren !== 2'b01 || seen_ready !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout got ren=%b seen_rdy=%b want 01/0", device_ren, seen_ready); end
    device_ready = 2'b01;
    device_data_read = {32'h0, 32'h7E57DA7A};
    tick();
    device_ready = 2'b00;
    exp_rdata = 32'h7E57DA7A;
    checks++; if (host_ready !== 1'b1 || host_error !== 1'b0 || host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL late_resp got rdy=%b err=%b data=%h want 1/0/%h", host_ready, host_error, host_data_read, exp_rdata); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_access();
    issue(32'h00010010, 1'b1, 1'b0, 32'hA5A5A5A5, 4'hF);
    checks++; if (device_wen !== 2'b10) begin errors++; $display("[TB] FAIL abort_pre got wen=%b want 10", device_wen); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_rdata = 32'h0;
    checks++; if ({device_wen, device_ren} !== 4'b0 || host_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_strobe got %b rdy=%b want 0000/0", {device_wen, device_ren}, host_ready); end
    checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL abort_rdata got %h want %h", host_data_read, exp_rdata); end
    tick();
    checks++; if (host_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_pulse got %b want 0", host_ready); end
    issue(32'h00000004, 1'b0, 1'b1, 32'h0, 4'h0);
    checks++; if (device_ren !== 2'b01) begin errors++; $display("[TB] FAIL abort_next_strobe got %b want 01", device_ren); end
    device_ready = 2'b01;
    device_data_read = {32'h0, 32'h600DCAFE};
    tick();
    device_ready = 2'b00;
    exp_rdata = 32'h600DCAFE;
    checks++; if (host_ready !== 1'b1 || host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL abort_next_resp got rdy=%b data=%h want 1/%h", host_ready, host_data_read, exp_rdata); end
    tick();
  endtask

  // Random traffic across both windows and the unmapped space, with random device latency
  // (up to TMO-1 extra cycles) and spurious ready pulses from the unselected device.
  task automatic test_random();
    logic [31:0] a, wd;
    logic [3:0]  m;
    logic        w, r;
    logic [1:0]  vec;
    int          d, lat, reg_sel;
    for (int t = 0; t < 60; t++) begin
      reg_sel = $urandom_range(0, 2);
      if (reg_sel == 0)      a = {16'h0000, 16'($urandom)};
      else if (reg_sel == 1) a = {16'h0001, 16'($urandom)};
      else                   a = {16'($urandom_range(2, 65535)), 16'($urandom)};
      w   = 1'($urandom_range(0, 1));
      r   = w ? 1'($urandom_range(0, 1)) : 1'b1;
      wd  = $urandom;
      m   = 4'($urandom);
      lat = $urandom_range(0, TMO - 1);
      device_data_read = {32'($urandom), 32'($urandom)};
      issue(a, w, r, wd, m);
      d = ref_dev(a);
      if (d < 0) begin
        if (!w) exp_rdata = ERRD;
        checks++; if (host_ready !== 1'b1 || host_error !== 1'b1 || {device_wen, device_ren} !== 4'b0) begin errors++; $display("[TB] FAIL rnd_unmapped a=%h got rdy=%b err=%b str=%b want 1/1/0000", a, host_ready, host_error, {device_wen, device_ren}); end
      end else begin
        vec = 2'b01 << d;
        for (int k = 0; k <= lat; k++) begin
          checks++; if ((w ? device_wen : device_ren) !== vec || (w ? device_ren : device_wen) !== 2'b00 || host_ready !== 1'b0) begin errors++; $display("[TB] FAIL rnd_strobe a=%h k=%0d got wen=%b ren=%b rdy=%b want %b", a, k, device_wen, device_ren, host_ready, vec); end
          device_ready = 2'b00;
          device_ready[1 - d] = 1'($urandom_range(0, 1));
          if (k == lat) device_ready[d] = 1'b1;
          tick();
        end
        device_ready = 2'b00;
        if (!w) exp_rdata = device_data_read[d*32 +: 32];
        checks++; if (host_ready !== 1'b1 || host_error !== 1'b0) begin errors++; $display("[TB] FAIL rnd_resp a=%h got rdy=%b err=%b want 1/0", a, host_ready, host_error); end
        if (w) begin
          checks++; if (device_write_mask[d*4 +: 4] !== m || device_data_write[d*32 +: 32] !== wd || device_address[d*32 +: 32] !== a) begin errors++; $display("[TB] FAIL rnd_wlatch got m=%b d=%h a=%h want %b/%h/%h", device_write_mask[d*4 +: 4], device_data_write[d*32 +: 32], device_address[d*32 +: 32], m, wd, a); end
        end
      end
      checks++; if (host_data_read !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_rdata a=%h w=%b got %h want %h", a, w, host_data_read, exp_rdata); end
      tick();
      checks++; if (host_ready !== 1'b0) begin errors++; $display("[TB] FAIL rnd_pulse got %b want 0", host_ready); end
    end
  endtask

  initial begin
    rst = 1'b0;
    host_wen = 1'b0; host_ren = 1'b0;
    host_address = '0; host_data_write = '0; host_write_mask = '0;
    device_ready = '0; device_data_read = '0;
    exp_rdata = '0;
    test_reset();
    test_read_dev1();
    test_write_dev0();
    test_unmapped();
    test_wen_ren_both();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
